// File: rtl/sa3x3_ctrl.sv
// sa3x3_ctrl: sequencer for a 3x3 systolic array.
// Holds 3x3 data (D) and weight (W) register files and clears the array.
// It then feeds skewed diagonals over five cycles and waits DRAIN cycles.
// Finally it captures the array sum and holds it until the consumer takes it.
// Ports:
//   clk, rst                       clock, async active-low reset
//   cfg_we/sel/addr/wdata, cfg_err register-file write port, sticky drop flag
//   start, busy                    run request, activity status
//   res_valid/ready/data           result handshake
//   sa_din0..2, sa_win0..2         data lanes (rows), weight lanes (columns)
//   sa_clear, sa_out               accumulator clear, array sum input
module sa3x3_ctrl #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DRAIN = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic          cfg_sel,
    input  logic [3:0]    cfg_addr,
    input  logic [DW-1:0] cfg_wdata,
    output logic          cfg_err,
    input  logic          start,
    output logic          busy,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data,
    output logic [DW-1:0] sa_din0,
    output logic [DW-1:0] sa_din1,
    output logic [DW-1:0] sa_din2,
    output logic [DW-1:0] sa_win0,
    output logic [DW-1:0] sa_win1,
    output logic [DW-1:0] sa_win2,
    output logic          sa_clear,
    input  logic [DW-1:0] sa_out
);

    localparam logic [3:0] FEED_LAST  = 4'd4;
    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_HOLD
    } state_t;

    state_t        state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic [DW-1:0] d_mem [9];
    logic [DW-1:0] w_mem [9];
    logic [DW-1:0] din_q [3];
    logic [DW-1:0] win_q [3];
    logic [DW-1:0] din_n [3];
    logic [DW-1:0] win_n [3];
    logic          cfg_ok;
    logic          cfg_drop;
    logic          start_acc;

    assign cfg_ok    = cfg_we && (state == ST_IDLE) && (cfg_addr <= 4'd8);
    assign cfg_drop  = cfg_we && !cfg_ok;
    assign start_acc = (state == ST_IDLE) && start;

    assign sa_din0 = din_q[0];
    assign sa_din1 = din_q[1];
    assign sa_din2 = din_q[2];
    assign sa_win0 = win_q[0];
    assign sa_win1 = win_q[1];
    assign sa_win2 = win_q[2];

    // Next state; cnt_n is the feed step t (or drain step) of the next cycle
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            ST_IDLE:  if (start) state_n = ST_CLEAR;
            ST_CLEAR: begin
                state_n = ST_FEED;
                cnt_n   = 4'd0;
            end
            ST_FEED: begin
                if (cnt == FEED_LAST) begin
                    state_n = ST_DRAIN;
                    cnt_n   = 4'd0;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            ST_DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    state_n = ST_HOLD;
                    cnt_n   = 4'd0;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            ST_HOLD:  if (res_ready) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Skewed lane values for the coming cycle: row i gets D[i][t-i], col j gets W[t-j][j]
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            din_n[i] = '0;
            win_n[i] = '0;
        end
        if (state_n == ST_FEED) begin
            for (int i = 0; i < 3; i++) begin
                if ((int'(cnt_n) >= i) && (int'(cnt_n) <= i + 2)) begin
                    din_n[i] = d_mem[4'(i * 3 + (int'(cnt_n) - i))];
                    win_n[i] = w_mem[4'((int'(cnt_n) - i) * 3 + i)];
                end
            end
        end
    end

    // State, register files and all registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            busy      <= 1'b0;
            sa_clear  <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            cfg_err   <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                d_mem[i] <= '0;
                w_mem[i] <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                din_q[i] <= '0;
                win_q[i] <= '0;
            end
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            busy      <= (state_n != ST_IDLE);
            sa_clear  <= (state_n == ST_CLEAR);
            res_valid <= (state_n == ST_HOLD);
            if ((state == ST_DRAIN) && (state_n == ST_HOLD)) res_data <= sa_out;
            // A drop on the start edge still leaves the flag set
            cfg_err <= (start_acc ? 1'b0 : cfg_err) | cfg_drop;
            if (cfg_ok) begin
                if (cfg_sel) w_mem[cfg_addr] <= cfg_wdata;
                else         d_mem[cfg_addr] <= cfg_wdata;
            end
            for (int i = 0; i < 3; i++) begin
                din_q[i] <= din_n[i];
                win_q[i] <= win_n[i];
            end
        end
    end

endmodule

// File: tb/tb_sa3x3_ctrl.sv
// Directed testbench for sa3x3_ctrl: reset, lane skew, result handshake,
// config drop/error, write-with-start, mid-run reset, ignored starts.
module tb_sa3x3_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned DRAIN = 4;

    logic          clk;
    logic          rst;
    logic          cfg_we;
    logic          cfg_sel;
    logic [3:0]    cfg_addr;
    logic [DW-1:0] cfg_wdata;
    logic          cfg_err;
    logic          start;
    logic          busy;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic [DW-1:0] sa_din0, sa_din1, sa_din2;
    logic [DW-1:0] sa_win0, sa_win1, sa_win2;
    logic          sa_clear;
    logic [DW-1:0] sa_out;

    int n_assert = 0;
    int n_fail   = 0;
    logic saw_valid;

    sa3x3_ctrl #(.DW(DW), .DRAIN(DRAIN)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_err   (cfg_err),
        .start     (start),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .sa_din0   (sa_din0),
        .sa_din1   (sa_din1),
        .sa_din2   (sa_din2),
        .sa_win0   (sa_win0),
        .sa_win1   (sa_win1),
        .sa_win2   (sa_win2),
        .sa_clear  (sa_clear),
        .sa_out    (sa_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_lanes(input string tag, input int d0, input int d1, input int d2,
                             input int w0, input int w1, input int w2);
        chk({tag, ".din0"}, 32'(sa_din0), 32'(d0));
        chk({tag, ".din1"}, 32'(sa_din1), 32'(d1));
        chk({tag, ".din2"}, 32'(sa_din2), 32'(d2));
        chk({tag, ".win0"}, 32'(sa_win0), 32'(w0));
        chk({tag, ".win1"}, 32'(sa_win1), 32'(w1));
        chk({tag, ".win2"}, 32'(sa_win2), 32'(w2));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic sel, input int addr, input int data);
        cfg_we    = 1'b1;
        cfg_sel   = sel;
        cfg_addr  = 4'(addr);
        cfg_wdata = 8'(data);
        step();
        cfg_we    = 1'b0;
    endtask

    initial begin
        rst = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = 4'd0; cfg_wdata = '0;
        start = 1'b0; res_ready = 1'b0; sa_out = '0;
        step(); step();

        // Reset state
        chk("rst.busy", 32'(busy), 0);
        chk("rst.valid", 32'(res_valid), 0);
        chk("rst.err", 32'(cfg_err), 0);
        chk("rst.clear", 32'(sa_clear), 0);
        chk("rst.data", 32'(res_data), 0);
        chk_lanes("rst", 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step();

        // Run 1: D = 1..9, W = 1, start in FEED and HOLD ignored
        for (int k = 0; k < 9; k++) wr(1'b0, k, k + 1);
        for (int k = 0; k < 9; k++) wr(1'b1, k, 1);
        sa_out = 8'h3C;
        start = 1'b1; step(); start = 1'b0;
        chk("r1.clear", 32'(sa_clear), 1);
        chk("r1.busy", 32'(busy), 1);
        chk_lanes("r1.clr", 0, 0, 0, 0, 0, 0);
        step();
        chk("r1.clear_off", 32'(sa_clear), 0);
        chk_lanes("r1.t0", 1, 0, 0, 1, 0, 0);
        start = 1'b1; step(); start = 1'b0;
        chk_lanes("r1.t1", 2, 4, 0, 1, 1, 0);
        step();
        chk_lanes("r1.t2", 3, 5, 7, 1, 1, 1);
        step();
        chk_lanes("r1.t3", 0, 6, 8, 0, 1, 1);
        step();
        chk_lanes("r1.t4", 0, 0, 9, 0, 0, 1);
        step();
        chk_lanes("r1.drain", 0, 0, 0, 0, 0, 0);
        chk("r1.drain_busy", 32'(busy), 1);
        step(); step(); step();
        chk("r1.last_drain_valid", 32'(res_valid), 0);
        step();
        chk("r1.valid", 32'(res_valid), 1);
        chk("r1.data", 32'(res_data), 32'h3C);
        chk_lanes("r1.hold", 0, 0, 0, 0, 0, 0);
        sa_out = 8'h77;
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            start = 1'b0;
            chk("r1.hold_valid", 32'(res_valid), 1);
            chk("r1.hold_data", 32'(res_data), 32'h3C);
        end
        res_ready = 1'b1; step(); res_ready = 1'b0;
        chk("r1.done_busy", 32'(busy), 0);
        chk("r1.done_valid", 32'(res_valid), 0);
        step(); step(); step();
        chk("r1.no_queue_busy", 32'(busy), 0);
        chk("r1.no_queue_valid", 32'(res_valid), 0);

        // Run 2: distinct W, bad address, write with start, write in FEED
        for (int k = 0; k < 9; k++) wr(1'b1, k, 16 + k);
        chk("r2.err_pre", 32'(cfg_err), 0);
        wr(1'b0, 9, 8'hAB);
        chk("r2.err_addr9", 32'(cfg_err), 1);
        sa_out = 8'h5A;
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 4'd0; cfg_wdata = 8'hFF;
        start = 1'b1; res_ready = 1'b1;
        step();
        cfg_we = 1'b0; start = 1'b0;
        chk("r2.err_cleared", 32'(cfg_err), 0);
        chk("r2.clear", 32'(sa_clear), 1);
        step();
        chk_lanes("r2.t0", 8'hFF, 0, 0, 8'h10, 0, 0);
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 4'd1; cfg_wdata = 8'hEE;
        step();
        cfg_we = 1'b0;
        chk("r2.err_feed", 32'(cfg_err), 1);
        chk_lanes("r2.t1", 2, 4, 0, 8'h13, 8'h11, 0);
        step();
        chk_lanes("r2.t2", 3, 5, 7, 8'h16, 8'h14, 8'h12);
        step();
        chk_lanes("r2.t3", 0, 6, 8, 0, 8'h17, 8'h15);
        step();
        chk_lanes("r2.t4", 0, 0, 9, 0, 0, 8'h18);
        step(); step(); step(); step();
        chk("r2.early_ready_ignored", 32'(res_valid), 0);
        chk("r2.busy", 32'(busy), 1);
        step();
        chk("r2.valid", 32'(res_valid), 1);
        chk("r2.data", 32'(res_data), 32'h5A);
        step();
        res_ready = 1'b0;
        chk("r2.same_cycle_valid", 32'(res_valid), 0);
        chk("r2.same_cycle_busy", 32'(busy), 0);

        // Run 3: reset during DRAIN
        sa_out = 8'h99;
        start = 1'b1; step(); start = 1'b0;
        chk("r3.err_cleared", 32'(cfg_err), 0);
        for (int i = 0; i < 6; i++) step();
        chk("r3.in_drain_busy", 32'(busy), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("r3.rst_busy", 32'(busy), 0);
        chk("r3.rst_valid", 32'(res_valid), 0);
        chk("r3.rst_data", 32'(res_data), 0);
        chk("r3.rst_clear", 32'(sa_clear), 0);
        chk("r3.rst_err", 32'(cfg_err), 0);
        chk_lanes("r3.rst", 0, 0, 0, 0, 0, 0);
        step(); step();
        rst = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            saw_valid = saw_valid | res_valid;
        end
        chk("r3.no_valid", 32'(saw_valid), 0);
        chk("r3.idle_busy", 32'(busy), 0);

        // Run 4: register files were cleared by reset; run completes normally
        start = 1'b1; step(); start = 1'b0;
        chk("r4.clear", 32'(sa_clear), 1);
        step(); step(); step();
        chk_lanes("r4.t2", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step();
        chk("r4.last_drain_valid", 32'(res_valid), 0);
        step();
        chk("r4.valid", 32'(res_valid), 1);
        chk("r4.data", 32'(res_data), 32'h99);
        res_ready = 1'b1; step(); res_ready = 1'b0;
        chk("r4.done_busy", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sa3x3_ctrl.md
SA3X3_CTRL -- requirements
Module: sa3x3_ctrl

Interface
REQ-001 Parameter DW, default 8: operand and result width in bits.
REQ-002 Parameter DRAIN, default 4: idle cycles after feed, before result capture; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 cfg_we  input  1  configuration write strobe.
REQ-006 cfg_sel  input  1  0 = data register file D, 1 = weight register file W.
REQ-007 cfg_addr  input  4  entry index = row*3+col; valid range 0..8.
REQ-008 cfg_wdata  input  DW  write data.
REQ-009 cfg_err  output  1  sticky flag: a configuration write was dropped.
REQ-010 start  input  1  run request; sampled only in IDLE.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 res_valid  output  1  result available.
REQ-013 res_ready  input  1  consumer accepts the result.
REQ-014 res_data  output  DW  captured array result.
REQ-015 sa_din0/sa_din1/sa_din2  output  DW each  data lanes to array rows 0..2.
REQ-016 sa_win0/sa_win1/sa_win2  output  DW each  weight lanes to array columns 0..2.
REQ-017 sa_clear  output  1  accumulator clear to all PEs.
REQ-018 sa_out  input  DW  array sum output.

Function
REQ-019 FSM states SHALL be IDLE, CLEAR, FEED, DRAIN and HOLD. Transitions: IDLE->CLEAR on start; CLEAR->FEED after 1 cycle; FEED->DRAIN after 5 cycles; DRAIN->HOLD after DRAIN cycles; HOLD->IDLE on res_ready.
REQ-020 All sa_* outputs SHALL be registered; sa_clear = 1 exactly during CLEAR, 0 otherwise.
REQ-021 In FEED cycle t (0..4), sa_din_i SHALL equal D[i][t-i] when 0 <= t-i <= 2, else 0.
REQ-022 In FEED cycle t, sa_win_j SHALL equal W[t-j][j] when 0 <= t-j <= 2, else 0.
REQ-023 All lanes SHALL be 0 in IDLE, CLEAR, DRAIN and HOLD.
REQ-024 On the last DRAIN cycle, sa_out SHALL be captured into res_data and res_valid SHALL rise on the following edge.
REQ-025 Latency: start sampled at edge k gives CLEAR in cycle k+1, FEED in cycles k+2..k+6, and res_valid high from cycle k+7+DRAIN (k+11 at default).
REQ-026 In HOLD, res_valid and res_data SHALL remain stable until res_ready = 1.
REQ-027 res_valid and res_ready high in the same cycle: the FSM goes to IDLE, and res_valid and busy are 0 on the next cycle.
REQ-028 res_ready while res_valid = 0 SHALL be ignored.
REQ-029 A result SHALL pass through unmodified; no saturation or width change (modulo 2^DW as produced by the array).
REQ-030 A cfg write SHALL be accepted only in IDLE with cfg_addr <= 8; otherwise it SHALL be dropped and cfg_err set.
REQ-031 cfg_err SHALL clear on the edge that accepts start.
REQ-032 cfg_we and start together in IDLE: the write SHALL commit on that edge and SHALL be used by that run.
REQ-033 start outside IDLE SHALL be ignored and not queued.
REQ-034 D and W contents SHALL persist across runs until overwritten.

Reset
REQ-035 rst = 0 SHALL immediately force: state IDLE; D and W all 0; res_data 0; res_valid, busy, cfg_err, sa_clear 0; all lanes 0.
REQ-036 rst asserted mid-run SHALL abort the run with no res_valid pulse; the first run after release requires a new start.

Verification
REQ-037 Load D = 1..9 row-major and W all 1, pulse start -> sa_clear high 1 cycle; lane values per REQ-021/022 on FEED cycles (t=2: din = 3,5,7; win = 1,1,1); res_valid at start+11.
REQ-038 Hold res_ready = 0 for 5 cycles after res_valid -> res_valid and res_data stable throughout; res_ready = 1 -> busy = 0 on the next cycle.
REQ-039 Write with cfg_addr = 9 in IDLE, then a write during FEED -> both dropped, cfg_err = 1; next start clears cfg_err.
REQ-040 Write D[0] = 0xFF together with start -> the first FEED cycle drives sa_din0 = 0xFF.
REQ-041 Assert rst during DRAIN -> all outputs 0 asynchronously; no res_valid; a later start runs normally.
REQ-042 Pulse start during FEED and during HOLD -> ignored; exactly one result is produced.
